// File: rtl/elastic_data_status_pipeline.sv
// ---------------------------------------------------------------------------
// elastic_data_status_pipeline
//
// Purpose:
//   A PIPE_DEPTH-stage register pipeline that carries a data field and a status
//   field under a valid/ready handshake. Empty stages are refilled even while
//   later stages are stalled, so bubbles collapse. A synchronous flush discards
//   every in-flight beat. A registered occupancy count reports how many stages
//   currently hold a beat.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset (clears valids and status)
//   flush_i      discard all in-flight beats at the next edge
//   valid_i      upstream beat valid
//   ready_o      pipeline can accept a beat this cycle (combinational from ready_i)
//   data_i       upstream data
//   status_i     upstream status
//   valid_o      output stage holds a beat
//   ready_i      downstream accepts the beat
//   data_o       output stage data
//   status_o     output stage status (always 0 while valid_o is 0)
//   occupancy_o  number of valid stages, 0..PIPE_DEPTH
// ---------------------------------------------------------------------------
module elastic_data_status_pipeline #(
   parameter int  DATA_W     = 32,
   parameter int  STATUS_W   = 1,
   parameter int  PIPE_DEPTH = 2,
   localparam int OCC_W      = $clog2(PIPE_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [DATA_W-1:0]   data_i,
   input  logic [STATUS_W-1:0] status_i,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [DATA_W-1:0]   data_o,
   output logic [STATUS_W-1:0] status_o,
   output logic [OCC_W-1:0]    occupancy_o
);

   // A pipeline with no stages has no meaning, so stop elaboration.
   generate
      if (PIPE_DEPTH < 1) begin : g_bad_depth
         $error("elastic_data_status_pipeline: PIPE_DEPTH must be at least 1");
      end
   endgenerate

   // Stage 0 is the input stage and PIPE_DEPTH-1 is the output stage.
   logic [PIPE_DEPTH-1:0] vld;
   logic [PIPE_DEPTH-1:0] vld_src;
   logic [PIPE_DEPTH-1:0] vld_nxt;
   logic [PIPE_DEPTH-1:0] en;
   logic                  room;
   logic [DATA_W-1:0]     dat     [PIPE_DEPTH];
   logic [DATA_W-1:0]     dat_src [PIPE_DEPTH];
   logic [STATUS_W-1:0]   sts     [PIPE_DEPTH];
   logic [STATUS_W-1:0]   sts_src [PIPE_DEPTH];
   logic [OCC_W-1:0]      occ;
   logic [OCC_W-1:0]      occ_nxt;

   // Advance enables. A stage may advance when it is empty or when every
   // stage after it can advance. Walking from the output stage back to the
   // input with a running "room" flag gives the same result as the recursive
   // definition without reading en back into itself.
   always_comb begin
      en   = '0;
      room = ready_i;
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
         room  = room | ~vld[k];
         en[k] = room;
      end
   end

   // Each stage is loaded from the stage before it; stage 0 is loaded from
   // the upstream port. Building this as a separate source vector keeps the
   // stage update loop free of a special case for stage 0.
   always_comb begin
      vld_src    = '0;
      vld_src[0] = valid_i;
      dat_src[0] = data_i;
      sts_src[0] = status_i;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
         vld_src[k] = vld[k-1];
         dat_src[k] = dat[k-1];
         sts_src[k] = sts[k-1];
      end
   end

   // Next-state valid vector and its population count. The occupancy register
   // is loaded from this count so it always matches the valids after the edge.
   always_comb begin
      vld_nxt = '0;
      occ_nxt = '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         vld_nxt[k] = en[k] ? vld_src[k] : vld[k];
         occ_nxt    = occ_nxt + OCC_W'(vld_nxt[k]);
      end
   end

   // Control state: valids, status and occupancy. Reset and flush both empty
   // the pipeline; reset wins, though the effect on these registers is the
   // same. Status is zeroed whenever an invalid beat enters a stage so that
   // an empty output stage never shows stale status.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         vld <= '0;
         occ <= '0;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            sts[k] <= '0;
         end
      end else begin
         vld <= vld_nxt;
         occ <= occ_nxt;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (en[k]) begin
               sts[k] <= vld_src[k] ? sts_src[k] : '0;
            end
         end
      end
   end

   // Data registers carry no reset; their content is ignored whenever the
   // matching valid is low, so they simply follow the advance enables.
   always_ff @(posedge clk) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         if (en[k]) begin
            dat[k] <= dat_src[k];
         end
      end
   end

   // The handshake has no skid buffer, so ready_o is the input stage enable.
   assign ready_o     = en[0];
   assign valid_o     = vld[PIPE_DEPTH-1];
   assign data_o      = dat[PIPE_DEPTH-1];
   assign status_o    = sts[PIPE_DEPTH-1];
   assign occupancy_o = occ;

endmodule

// File: doc/elastic_data_status_pipeline.md
Name: elastic_data_status_pipeline

Overview:
- Next-generation data/status pipeline: PIPE_DEPTH register stages carrying a DATA_W data field and a STATUS_W status field.
- Adds a valid/ready handshake, per-stage bubble collapsing, a synchronous flush, and an occupancy count.
- Sits between parser sub-blocks where downstream logic (FCS check, field extractors, output FIFO) can apply backpressure, so a free-running pipeline is not acceptable.

Parameters:
- DATA_W, 32, data field width; ≥1.
- STATUS_W, 1, status field width; ≥1.
- PIPE_DEPTH, 2, number of register stages; ≥1. Elaboration error if 0.
- OCC_W, $clog2(PIPE_DEPTH+1), occupancy width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  discard all in-flight beats
- valid_i  in  1  upstream beat valid
- ready_o  out  1  pipeline can accept a beat this cycle
- data_i  in  DATA_W  upstream data
- status_i  in  STATUS_W  upstream status
- valid_o  out  1  output stage holds a beat
- ready_i  in  1  downstream accepts the beat
- data_o  out  DATA_W  output stage data
- status_o  out  STATUS_W  output stage status
- occupancy_o  out  OCC_W  number of valid stages

Behaviour:
- Interface decided: one clock, clk. Reset rst is synchronous and active-high.
- Stages are indexed 0 (input) to PIPE_DEPTH-1 (output). Each stage holds vld[k], dat[k] and sts[k].
- Advance enables:
  - en[PIPE_DEPTH-1] = !vld[PIPE_DEPTH-1] || ready_i
  - en[k] = !vld[k] || en[k+1]
- Handshake:
  - ready_o = en[0]. This is a combinational path from ready_i; no skid buffer is used.
  - Input accepted when valid_i && ready_o. Output transferred when valid_o && ready_i.
- Stage update on en[k]:
  - vld[k] <= vld[k-1] (stage 0: valid_i)
  - dat[k] <= dat[k-1] (stage 0: data_i)
  - sts[k] <= sts[k-1] if vld[k-1], else 0
  - If en[k] is low, the stage holds.
- Bubble collapsing: an empty stage is always loaded, even while the stages after it are stalled.
- Outputs: valid_o = vld[PIPE_DEPTH-1], data_o = dat[PIPE_DEPTH-1], status_o = sts[PIPE_DEPTH-1].
- Invariant: status_o is 0 whenever valid_o is 0.
- Latency: with ready_i held high, a beat accepted at edge N appears at valid_o after edge N+PIPE_DEPTH-1, i.e. PIPE_DEPTH cycles after presentation. Sustained throughput is 1 beat/cycle.
- Reset:
  - All vld and sts registers go to 0. valid_o=0, status_o=0, occupancy_o=0.
  - Data registers have no reset; data_o is don't-care while valid_o=0.
  - ready_o=1 after reset, because all stages are empty.
  - Reset mid-stream drops every in-flight beat. A beat presented in the reset cycle is not accepted.
- Flush:
  - flush_i=1 at an edge clears all vld and sts, the same as reset except data is untouched.
  - The beat accepted in the flush cycle is dropped.
  - ready_o is not gated by flush_i.
  - A beat transferred at the output in the flush cycle counts as delivered.
  - rst has priority over flush_i.
- occupancy_o is the registered count of set vld bits, range 0..PIPE_DEPTH.
  - Registered form: computed from the next-state vld vector and updated every edge.
  - occupancy_o==PIPE_DEPTH && !ready_i implies ready_o=0.
- Simultaneous accept and output transfer with a full pipeline: ready_o=1, all stages shift, occupancy is unchanged.
- Stall stability: with valid_o=1 and ready_i=0, data_o and status_o must not change until the transfer.

Test Plan:
- Streaming, PIPE_DEPTH=3, ready_i=1: drive data 0x01..0x08 with status[0]=1 on 0x08 each cycle → first valid_o 3 cycles after 0x01, 8 consecutive output beats in order, status_o=1 only with data_o=0x08, occupancy_o steady at 3.
- Backpressure fill: ready_i=0, drive 0xA0..0xA4 → 0xA0, 0xA1, 0xA2 accepted; ready_o=0 from the 4th cycle on; occupancy_o=3; data_o holds 0xA0. Then ready_i=1 → 0xA0, 0xA1, 0xA2, 0xA3, 0xA4 emitted with no loss or duplication.
- Bubble collapse: accept 0x11 with ready_i=0, idle 2 cycles, then accept 0x22 → 0x22 lands in stage 1 while 0x11 stalls in stage 2, occupancy_o=2, ready_o stays 1.
- Flush: 3 beats in flight, flush_i=1 for one cycle while valid_i=1 with 0x55 → next cycle valid_o=0, status_o=0, occupancy_o=0. 0x55 is never output.
- Reset mid-stream: assert rst with a full pipeline and ready_i=0 → next cycle valid_o=0, occupancy_o=0, ready_o=1. A subsequent beat 0x77 appears after exactly PIPE_DEPTH cycles.
- Random valid_i/ready_i at 50% for 10k beats on PIPE_DEPTH=1 and 4 → scoreboard shows in-order, lossless delivery, and status_o=0 whenever valid_o=0.
